board_ctrl: RTL and testbench
=============================

# board_ctrl

Game controller for the 4x4 grid display. It turns single-cycle button pulses into cursor moves and cell placements, alternates between the two players, and scans the board for a four-in-a-line win or a draw. It drives the board-state and cursor inputs of the pixel generator; cell k of `board` feeds pixel-generator input p(k+1), and `select_position` feeds its cursor input.

## Interface
- `CLEAR_DELAY`, default 25_000_000: cycles spent in WIN/DRAW before auto-clear. Used only when the macro in Configuration is defined; must be ≥1.
- `clk_d`  in  1  system/pixel clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced single-cycle move pulses, synchronous to `clk_d`.
- `btn_place`  in  1  single-cycle pulse; claim the cell under the cursor.
- `btn_new`  in  1  single-cycle pulse; start a new game.
- `board`  out  32  cell k in bits [2k+1:2k]; 00 empty, 01 player 1, 10 player 2.
- `select_position`  out  4  cursor index = row*4 + col.
- `turn`  out  1  0 = player 1 (code 01) to move; 1 = player 2 (code 10) to move.
- `winner`  out  2  00 none, 01/10 winning player, 11 draw.
- `game_over`  out  1  high in WIN and DRAW.
- `busy`  out  1  high in CHECK.

## Operation
- **Clear condition.** Reset, or `btn_new` sampled in any state. At the next edge:
  - `board`=0, `select_position`=0, `turn`=0, `winner`=00, `game_over`=0, `busy`=0.
  - occupancy count=0, line index=0, state=PLAY.
  - `rst` takes precedence over `btn_new`; `btn_new` takes precedence over every other input.
- **States:** PLAY, CHECK, WIN, DRAW.
- **PLAY:**
  - Exactly one button is acted on per cycle, priority place > up > down > left > right.
  - Up/down change row ±1 and left/right change column ±1, each mod 4. Wrap-around: row 0 up → row 3, col 3 right → col 0.
  - Place on an empty cell:
    - write code `turn ? 10 : 01` into that cell;
    - increment the 5-bit occupancy count;
    - line index←0, state←CHECK.
  - Place on an occupied cell is ignored, with no state change.
- **CHECK:** one line is evaluated per cycle against the current player's code. Line index order:
  - 0–3: rows 0–3.
  - 4–7: columns 0–3.
  - 8: cells {0,5,10,15}.
  - 9: cells {3,6,9,12}.
- **CHECK outcomes:**
  - All four cells of the evaluated line equal the current code → state←WIN, `winner`←current code, `game_over`←1.
  - Line 9 evaluated without a win and count=16 → state←DRAW, `winner`←11, `game_over`←1.
  - Line 9 evaluated without a win and count<16 → `turn` toggles, state←PLAY.
  - All move and place inputs are ignored in CHECK.
- **WIN/DRAW:** outputs held. Only `btn_new`, `rst` or auto-clear leave these states. Move and place inputs are ignored.

## Timing
- All outputs are registered; reset values as in the clear condition.
- Cursor move sampled at edge E → `select_position` updated after E.
- Place sampled at edge E0 → `board` and `busy`=1 visible after E0.
- Edge E(k+1) evaluates line k (k = 0..9).
  - A win on line k sets `game_over` after E(k+1). The earliest is after E1 (a row-0 win); `busy` falls at the same edge.
  - No win: `turn` toggles and `busy` falls after E10. The next place is accepted at E11 at the earliest.
- `btn_new` arriving during CHECK aborts the scan; the clear takes effect after that edge.
- `busy` and `game_over` are never high together.

## Configuration
- Macro: `BOARD_CTRL_AUTOCLEAR_EN`.
- **Defined:**
  - On entry to WIN or DRAW a counter of width ⌈log2(CLEAR_DELAY+1)⌉ is zeroed.
  - It increments each cycle; on reaching CLEAR_DELAY-1 the clear condition is applied at the next edge.
  - The counter is zeroed by `btn_new` and `rst`.
- **Not defined:** no counter exists. WIN/DRAW are held until `btn_new` or `rst`, and `CLEAR_DELAY` is unused.

## Test plan
- **Reset and cursor wrap.** Reset, then `btn_up` ×1 → `select_position`=12; then `btn_left` ×1 → 15; then `btn_right` → 12.
- **Placement and turn.** Place at 0 → `board[1:0]`=01, `busy` high for 10 cycles, then `turn`=1. Place at 0 again → ignored, `board` unchanged, `turn`=1.
- **Row win.** Player 1 places at cells 0,1,2,3 with player 2 at 4,5,6 interleaved. The final place → `winner`=01 and `game_over`=1 one cycle after `busy` rises. A `btn_place` then leaves `board` unchanged.
- **Anti-diagonal win.** Player 2 completes cells 3,6,9,12 → `winner`=10 after line 9 is evaluated, 10 cycles after the place.
- **Draw and new game.** Fill the board in a no-line pattern → `winner`=11, `game_over`=1. Then `btn_new` → all outputs at reset values next cycle.
- **Simultaneous events.** `btn_place`+`btn_up` in the same cycle → place only, cursor unchanged. `btn_new` during CHECK → cleared next cycle. With `BOARD_CTRL_AUTOCLEAR_EN` and `CLEAR_DELAY`=4 → clear exactly 4 cycles after `game_over` rises.

Source files
------------

// File: rtl/board_ctrl.sv
// 4x4 four-in-a-line game controller: cursor, placement, turn and win/draw scan.
// Optional auto-clear of finished games is enabled by BOARD_CTRL_AUTOCLEAR_EN.
module board_ctrl #(
   parameter int CLEAR_DELAY = 25_000_000
) (
   input  logic        clk_d,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_place,
   input  logic        btn_new,
   output logic [31:0] board,
   output logic [3:0]  select_position,
   output logic        turn,
   output logic [1:0]  winner,
   output logic        game_over,
   output logic        busy
);

   typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

   state_t      state, state_n;
   logic [31:0] board_n;
   logic [1:0]  row, row_n;
   logic [1:0]  col, col_n;
   logic        turn_n;
   logic [1:0]  winner_n;
   logic [4:0]  cnt, cnt_n;
   logic [3:0]  line, line_n;
   logic [1:0]  code;
   logic [15:0] mask;
   logic        line_win;
   logic        cell_empty;
   logic        ac_fire;

   assign select_position = {row, col};
   assign code            = turn ? 2'b10 : 2'b01;
   assign game_over       = (state == WIN) || (state == DRAW);
   assign busy            = (state == CHECK);
   assign cell_empty      = (board[{row, col, 1'b0} +: 2] == 2'b00);

   // Cells belonging to the line under evaluation
   always_comb begin
      mask = 16'h0000;
      case (line)
         4'd0, 4'd1, 4'd2, 4'd3: mask = 16'h000F << {line[1:0], 2'b00};
         4'd4, 4'd5, 4'd6, 4'd7: mask = 16'h1111 << line[1:0];
         4'd8:                   mask = 16'h8421;
         4'd9:                   mask = 16'h1248;
         default:                mask = 16'h0000;
      endcase
   end

   always_comb begin
      line_win = (mask != 16'h0000);
      for (int i = 0; i < 16; i++) begin
         if (mask[i] && board[2*i +: 2] != code)
            line_win = 1'b0;
      end
   end

`ifdef BOARD_CTRL_AUTOCLEAR_EN
   localparam int AW = $clog2(CLEAR_DELAY + 1);
   localparam logic [AW-1:0] AC_LAST = AW'(CLEAR_DELAY - 1);

   logic [AW-1:0] ac_cnt;

   assign ac_fire = game_over && (ac_cnt == AC_LAST);

   // Held at zero through CHECK so it starts from zero on WIN/DRAW entry
   always_ff @(posedge clk_d) begin
      if (rst || btn_new || state == CHECK)
         ac_cnt <= '0;
      else if (game_over)
         ac_cnt <= ac_cnt + 1'b1;
   end
`else
   assign ac_fire = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      board_n  = board;
      row_n    = row;
      col_n    = col;
      turn_n   = turn;
      winner_n = winner;
      cnt_n    = cnt;
      line_n   = line;
      if (btn_new || ac_fire) begin
         state_n  = PLAY;
         board_n  = '0;
         row_n    = '0;
         col_n    = '0;
         turn_n   = 1'b0;
         winner_n = 2'b00;
         cnt_n    = '0;
         line_n   = '0;
      end else begin
         unique case (state)
            PLAY: begin
               priority case (1'b1)
                  btn_place: begin
                     if (cell_empty) begin
                        board_n[{row, col, 1'b0} +: 2] = code;
                        cnt_n   = cnt + 5'd1;
                        line_n  = '0;
                        state_n = CHECK;
                     end
                  end
                  btn_up:    row_n = row - 2'd1;
                  btn_down:  row_n = row + 2'd1;
                  btn_left:  col_n = col - 2'd1;
                  btn_right: col_n = col + 2'd1;
                  default: ;
               endcase
            end
            CHECK: begin
               if (line_win) begin
                  state_n  = WIN;
                  winner_n = code;
               end else if (line == 4'd9) begin
                  if (cnt == 5'd16) begin
                     state_n  = DRAW;
                     winner_n = 2'b11;
                  end else begin
                     turn_n  = ~turn;
                     state_n = PLAY;
                  end
               end else begin
                  line_n = line + 4'd1;
               end
            end
            WIN, DRAW: ;
            default: state_n = PLAY;
         endcase
      end
   end

   always_ff @(posedge clk_d) begin
      if (rst) begin
         state  <= PLAY;
         board  <= '0;
         row    <= '0;
         col    <= '0;
         turn   <= 1'b0;
         winner <= 2'b00;
         cnt    <= '0;
         line   <= '0;
      end else begin
         state  <= state_n;
         board  <= board_n;
         row    <= row_n;
         col    <= col_n;
         turn   <= turn_n;
         winner <= winner_n;
         cnt    <= cnt_n;
         line   <= line_n;
      end
   end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: game-level reference model feeds an
// expectation queue, an independent monitor compares every cycle.
module tb_board_ctrl;

   localparam int CD = 4;

   localparam logic [6:0] RST = 7'b1000000;
   localparam logic [6:0] NEW = 7'b0100000;
   localparam logic [6:0] PL  = 7'b0010000;
   localparam logic [6:0] UP  = 7'b0001000;
   localparam logic [6:0] DN  = 7'b0000100;
   localparam logic [6:0] LF  = 7'b0000010;
   localparam logic [6:0] RT  = 7'b0000001;

   logic        clk_d = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0;
   logic        btn_left = 1'b0, btn_right = 1'b0;
   logic        btn_place = 1'b0, btn_new = 1'b0;
   logic [31:0] board;
   logic [3:0]  select_position;
   logic        turn;
   logic [1:0]  winner;
   logic        game_over;
   logic        busy;

   always #5 clk_d = ~clk_d;

   board_ctrl #(.CLEAR_DELAY(CD)) dut (
      .clk_d(clk_d), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right),
      .btn_place(btn_place), .btn_new(btn_new),
      .board(board), .select_position(select_position),
      .turn(turn), .winner(winner),
      .game_over(game_over), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] board;
      logic [3:0]  sel;
      logic        turn;
      logic [1:0]  winner;
      logic        go;
      logic        busy;
   } obs_t;

   obs_t expq[$];
   int   tests = 0;
   int   fails = 0;

   // Game-level model: a placement resolves its outcome immediately;
   // busy_left counts the cycles until that outcome becomes visible.
   int cells[16];
   int cr, cc, mwin, busy_left, outcome, ocnt;
   bit mturn, mover;

   function automatic int line_cell(int k, int i);
      if (k < 4) return k * 4 + i;
      if (k < 8) return i * 4 + (k - 4);
      if (k == 8) return i * 5;
      return 3 + 3 * i;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) cells[i] = 0;
      cr = 0; cc = 0; mturn = 0; mwin = 0; mover = 0;
      busy_left = 0; outcome = 0; ocnt = 0;
   endtask

   task automatic m_step(input logic [6:0] v);
      int pos, code, win_k;
      bit full, all4;
      if (v[6] || v[5]) begin
         m_clear();
      end else if (mover) begin
`ifdef BOARD_CTRL_AUTOCLEAR_EN
         if (ocnt == CD - 1) m_clear();
         else ocnt++;
`endif
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            if (outcome == 1) begin
               mwin = mturn ? 2 : 1; mover = 1; ocnt = 0;
            end else if (outcome == 2) begin
               mwin = 3; mover = 1; ocnt = 0;
            end else begin
               mturn = !mturn;
            end
         end
      end else if (v[4]) begin
         pos = cr * 4 + cc;
         if (cells[pos] == 0) begin
            code = mturn ? 2 : 1;
            cells[pos] = code;
            win_k = -1;
            for (int k = 0; k < 10; k++) begin
               all4 = 1;
               for (int i = 0; i < 4; i++)
                  if (cells[line_cell(k, i)] != code) all4 = 0;
               if (all4 && win_k < 0) win_k = k;
            end
            if (win_k >= 0) begin
               busy_left = win_k + 1; outcome = 1;
            end else begin
               full = 1;
               for (int i = 0; i < 16; i++) if (cells[i] == 0) full = 0;
               busy_left = 10; outcome = full ? 2 : 0;
            end
         end
      end else if (v[3]) cr = (cr + 3) % 4;
      else if (v[2]) cr = (cr + 1) % 4;
      else if (v[1]) cc = (cc + 3) % 4;
      else if (v[0]) cc = (cc + 1) % 4;
   endtask

   function automatic obs_t m_obs();
      obs_t o;
      for (int i = 0; i < 16; i++) o.board[2*i +: 2] = 2'(cells[i]);
      o.sel    = 4'(cr * 4 + cc);
      o.turn   = mturn;
      o.winner = 2'(mwin);
      o.go     = mover;
      o.busy   = (busy_left > 0);
      return o;
   endfunction

   task automatic cyc(input logic [6:0] v);
      {rst, btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = v;
      m_step(v);
      expq.push_back(m_obs());
      @(posedge clk_d);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(7'b0);
   endtask

   task automatic goto_cell(input int pos);
      for (int i = 0; i < 4 && cr != pos / 4; i++) cyc(DN);
      for (int i = 0; i < 4 && cc != pos % 4; i++) cyc(RT);
   endtask

   task automatic place_at(input int pos);
      goto_cell(pos);
      cyc(PL);
      for (int i = 0; i < 12 && busy_left > 0; i++) cyc(7'b0);
   endtask

   // Monitor: one popped expectation per clock edge
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk_d);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {board, select_position, turn, winner, game_over, busy};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs t=%0t board %h/%h sel %0d/%0d turn %0b/%0b win %0d/%0d go %0b/%0b busy %0b/%0b (got/want)",
                        $time, a.board, e.board, a.sel, e.sel, a.turn, e.turn,
                        a.winner, e.winner, a.go, e.go, a.busy, e.busy);
            end
         end
      end
   end

   int p1_draw[8] = '{0, 1, 6, 7, 8, 9, 14, 15};
   int p2_draw[8] = '{2, 3, 4, 5, 10, 11, 12, 13};

   initial begin
      logic [6:0] v;
      m_clear();
      cyc(RST);
      cyc(RST);
      // cursor wrap
      cyc(UP); cyc(LF); cyc(RT);
      // placement, then re-place on occupied cell
      goto_cell(0);
      cyc(PL);
      idle(11);
      cyc(PL);
      idle(2);
      // row win by player 1
      cyc(NEW);
      place_at(0); place_at(4); place_at(1); place_at(5);
      place_at(2); place_at(6); place_at(3);
      cyc(PL); cyc(UP); idle(2);
      // anti-diagonal win by player 2
      cyc(NEW);
      place_at(0); place_at(3); place_at(1); place_at(6);
      place_at(2); place_at(9); place_at(4); place_at(12);
      idle(3);
      // draw, then new game
      cyc(NEW);
      for (int i = 0; i < 8; i++) begin
         place_at(p1_draw[i]);
         place_at(p2_draw[i]);
      end
      idle(6);
      cyc(NEW);
      idle(1);
      // simultaneous events
      goto_cell(5);
      cyc(PL | UP);
      idle(3);
      cyc(NEW);
      idle(1);
      cyc(RST | NEW);
      goto_cell(2);
      cyc(PL);
      idle(2);
      cyc(RST);
      idle(1);
      // randomized play
      repeat (4000) begin
         v = 7'b0;
         if ($urandom_range(0, 599) == 0) v[6] = 1'b1;
         if ($urandom_range(0, 149) == 0) v[5] = 1'b1;
         if ($urandom_range(0, 3) == 0) v[4] = 1'b1;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 4) == 0) v[b] = 1'b1;
         cyc(v);
      end
      cyc(7'b0);
      @(posedge clk_d);
      #2;
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d want 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
